ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048575: cycles a prefix state may wait for its next byte before abandoning the sequence.
REQ-002 SHALL have parameter PAUSE_SKIP, default 7: bytes discarded after an E1 prefix.
REQ-003 SHALL have port CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_data  input  8  received scan-code byte from PS/2 controller.
REQ-006 SHALL have port ps2_data_en  input  1  one-cycle strobe: ps2_data valid this cycle.
REQ-007 SHALL have port clear_keys  input  1  synchronous clear of all held keys and the parser.
REQ-008 SHALL have ports up1, left1, down1, right1  output  1 each  player-1 held levels (W 0x1D, A 0x1C, S 0x1B, D 0x23).
REQ-009 SHALL have ports up2, left2, down2, right2  output  1 each  player-2 held levels (extended E0 75, E0 6B, E0 72, E0 74).
REQ-010 SHALL have ports fire1, fire2  output  1 each  held levels (Space 0x29; keypad-0 0x70, non-extended).
REQ-011 SHALL have port start_game  output  1  one-cycle pulse on Enter make (0x5A, non-extended).
REQ-012 SHALL have port key_event  output  1  one-cycle pulse whenever any mapped key output changes or start_game pulses.

Function
REQ-013 SHALL accept a byte only in a cycle where ps2_data_en=1; all outputs registered, updating on the edge after acceptance (1-cycle latency).
REQ-014 SHALL implement parser states IDLE, BREAK, EXT, EXT_BREAK, PAUSE.
REQ-015 IDLE: 0xF0 -> BREAK; 0xE0 -> EXT; 0xE1 -> PAUSE (skip counter loaded PAUSE_SKIP); other byte = non-extended make, stay IDLE.
REQ-016 BREAK: 0xE0 -> EXT_BREAK; 0xF0 -> stay BREAK; other byte = non-extended break -> IDLE.
REQ-017 EXT: 0xF0 -> EXT_BREAK; 0xE0 -> stay EXT; other byte = extended make -> IDLE.
REQ-018 EXT_BREAK: 0xF0/0xE0 -> stay; other byte = extended break -> IDLE.
REQ-019 PAUSE: each accepted byte decrements skip counter with no output effect; at the byte reaching 0 -> IDLE.
REQ-020 Make of a mapped level key SHALL set its output to 1; break SHALL clear it to 0; repeated makes (typematic) SHALL hold 1 with no further key_event.
REQ-021 Extended and non-extended codes SHALL be distinct: E0 1D, E0 5A, E0 70 SHALL NOT affect up1, start_game or fire2.
REQ-022 Unmapped codes SHALL complete their sequence and return to IDLE with no output change.
REQ-023 start_game SHALL pulse exactly one cycle on Enter make only when internal enter_held=0; enter_held set on make, cleared on break; typematic repeats SHALL NOT re-pulse.
REQ-024 Opposing directions held together (e.g. up1 and down1) SHALL both read 1; no priority applied.
REQ-025 Timeout counter SHALL clear on every accepted byte, count only in states other than IDLE, and at TIMEOUT_CYCLES force IDLE with no output change; saturate, no wrap.
REQ-026 clear_keys=1 SHALL, on the next edge, clear all level outputs, enter_held and the timeout counter, force IDLE, and discard any byte strobed in the same cycle; key_event pulses if any output was 1.
REQ-027 key_event SHALL be 0 on cycles where no output changes.

Reset
REQ-028 rstn=0 SHALL immediately force all outputs 0, enter_held 0, skip and timeout counters 0, state IDLE, regardless of clock.
REQ-029 Reset mid-sequence (e.g. after E0 F0) SHALL discard the partial sequence; the first byte after release is parsed from IDLE.

Verification
REQ-030 Bytes 1D, F0 1D -> up1=1 one cycle after the first strobe, key_event pulses; up1=0 one cycle after the final 1D, key_event pulses.
REQ-031 Bytes E0 75, 1D, E0 F0 75 -> up2=1 then up1=1; after E0 F0 75 up2=0, up1 stays 1.
REQ-032 Bytes 5A, 5A, 5A, F0 5A, 5A -> start_game exactly 2 single-cycle pulses (first and last make).
REQ-033 Bytes E0 (then no strobe for TIMEOUT_CYCLES), 1D -> 1D parsed as non-extended make, up1=1; E1 followed by 7 arbitrary bytes incl. 1D -> no output change, next 29 sets fire1=1.
REQ-034 Hold 1C, 29; strobe 23 with clear_keys=1 same cycle -> left1, fire1, right1 all 0 next cycle, one key_event pulse.
REQ-035 Strobe E0, F0, assert rstn=0 asynchronously, release, strobe 72 -> no output change (72 non-extended, unmapped), state IDLE.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Byte-strobe input and decoded key outputs of the PS/2 key decoder.
interface ps2_key_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_data_en;
    logic       clear_keys;
    logic       up1, left1, down1, right1;
    logic       up2, left2, down2, right2;
    logic       fire1, fire2;
    logic       start_game;
    logic       key_event;

    modport master (
        output ps2_data, ps2_data_en, clear_keys,
        input  up1, left1, down1, right1, up2, left2, down2, right2,
        input  fire1, fire2, start_game, key_event
    );

    modport slave (
        input  ps2_data, ps2_data_en, clear_keys,
        output up1, left1, down1, right1, up2, left2, down2, right2,
        output fire1, fire2, start_game, key_event
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Parses PS/2 set-2 scan-code bytes into held game-key levels, a start pulse
// and a change strobe. Unfinished prefix sequences are abandoned after a timeout.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input logic              CLOCK_50,
    input logic              rstn,
    ps2_key_decoder_if.slave bus
);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SK_W  = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);
    localparam int unsigned NKEYS = 10;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK, S_PAUSE
    } state_t;

    state_t            state_q, state_d;
    logic [NKEYS-1:0]  keys_q, keys_d;
    logic              enter_q, enter_d;
    logic [SK_W-1:0]   skip_q, skip_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              start_q, start_d;
    logic              event_q, event_d;

    // Bit order: up1 left1 down1 right1 up2 left2 down2 right2 fire1 fire2
    function automatic logic [NKEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NKEYS-1:0] m;
        m = '0;
        case ({ext, code})
            9'h01D: m[0] = 1'b1;
            9'h01C: m[1] = 1'b1;
            9'h01B: m[2] = 1'b1;
            9'h023: m[3] = 1'b1;
            9'h175: m[4] = 1'b1;
            9'h16B: m[5] = 1'b1;
            9'h172: m[6] = 1'b1;
            9'h174: m[7] = 1'b1;
            9'h029: m[8] = 1'b1;
            9'h070: m[9] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    always_comb begin
        logic             code_valid;
        logic             code_ext;
        logic             code_brk;
        logic [NKEYS-1:0] mask;
        state_d    = state_q;
        keys_d     = keys_q;
        enter_d    = enter_q;
        skip_d     = skip_q;
        to_d       = to_q;
        start_d    = 1'b0;
        code_valid = 1'b0;
        code_ext   = 1'b0;
        code_brk   = 1'b0;
        mask       = '0;

        if (bus.clear_keys) begin
            state_d = S_IDLE;
            keys_d  = '0;
            enter_d = 1'b0;
            skip_d  = '0;
            to_d    = '0;
        end else if (bus.ps2_data_en) begin
            to_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ps2_data == 8'hF0)      state_d = S_BREAK;
                    else if (bus.ps2_data == 8'hE0) state_d = S_EXT;
                    else if (bus.ps2_data == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = SK_W'(PAUSE_SKIP);
                    end else code_valid = 1'b1;
                end
                S_BREAK: begin
                    if (bus.ps2_data == 8'hE0)      state_d = S_EXT_BREAK;
                    else if (bus.ps2_data != 8'hF0) begin
                        code_valid = 1'b1;
                        code_brk   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (bus.ps2_data == 8'hF0)      state_d = S_EXT_BREAK;
                    else if (bus.ps2_data != 8'hE0) begin
                        code_valid = 1'b1;
                        code_ext   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_EXT_BREAK: begin
                    if (bus.ps2_data != 8'hF0 && bus.ps2_data != 8'hE0) begin
                        code_valid = 1'b1;
                        code_ext   = 1'b1;
                        code_brk   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    // Pause/Break sends a fixed tail with no matching break code
                    if (skip_q <= SK_W'(1)) begin
                        skip_d  = '0;
                        state_d = S_IDLE;
                    end else skip_d = skip_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (to_q == TO_MAX) begin
                state_d = S_IDLE;
                skip_d  = '0;
            end else to_d = to_q + 1'b1;
        end

        if (code_valid) begin
            mask   = key_mask(code_ext, bus.ps2_data);
            keys_d = code_brk ? (keys_q & ~mask) : (keys_q | mask);
            if (!code_ext && bus.ps2_data == 8'h5A) begin
                if (code_brk) enter_d = 1'b0;
                else begin
                    start_d = ~enter_q;
                    enter_d = 1'b1;
                end
            end
        end

        event_d = (keys_d != keys_q) | start_d;
    end

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            keys_q  <= '0;
            enter_q <= 1'b0;
            skip_q  <= '0;
            to_q    <= '0;
            start_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            enter_q <= enter_d;
            skip_q  <= skip_d;
            to_q    <= to_d;
            start_q <= start_d;
            event_q <= event_d;
        end
    end

    assign bus.up1        = keys_q[0];
    assign bus.left1      = keys_q[1];
    assign bus.down1      = keys_q[2];
    assign bus.right1     = keys_q[3];
    assign bus.up2        = keys_q[4];
    assign bus.left2      = keys_q[5];
    assign bus.down2      = keys_q[6];
    assign bus.right2     = keys_q[7];
    assign bus.fire1      = keys_q[8];
    assign bus.fire2      = keys_q[9];
    assign bus.start_game = start_q;
    assign bus.key_event  = event_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a flag-based
// behavioural model of the scan-code protocol.
module tb_ps2_key_decoder;
    localparam int unsigned TO   = 40;
    localparam int unsigned SKIP = 7;

    logic CLOCK_50;
    logic rstn;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TO),
        .PAUSE_SKIP    (SKIP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rstn    (rstn),
        .bus     (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;
    int start_seen = 0;

    // Model: pending prefix flags rather than a state machine
    bit       m_brk, m_ext, m_enter, exp_start, exp_event;
    int       m_pause, m_idle;
    bit [9:0] m_keys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_bit(input bit ext, input logic [7:0] code);
        int k;
        k = -1;
        if (!ext) begin
            case (code)
                8'h1D: k = 0;  8'h1C: k = 1;  8'h1B: k = 2;  8'h23: k = 3;
                8'h29: k = 8;  8'h70: k = 9;
                default: k = -1;
            endcase
        end else begin
            case (code)
                8'h75: k = 4;  8'h6B: k = 5;  8'h72: k = 6;  8'h74: k = 7;
                default: k = -1;
            endcase
        end
        return k;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_enter = 0; m_pause = 0; m_idle = 0;
        m_keys = '0; exp_start = 0; exp_event = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] d, input bit clr);
        bit [9:0] prev;
        int k;
        prev = m_keys;
        exp_start = 0;
        if (clr) begin
            m_keys = '0; m_enter = 0; m_brk = 0; m_ext = 0; m_pause = 0; m_idle = 0;
        end else if (en) begin
            m_idle = 0;
            if (m_pause > 0) m_pause--;
            else if (!m_brk && !m_ext && d == 8'hE1) m_pause = SKIP;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE0) m_ext = 1;
            else begin
                k = key_bit(m_ext, d);
                if (k >= 0) m_keys[k] = !m_brk;
                if (!m_ext && d == 8'h5A) begin
                    if (m_brk) m_enter = 0;
                    else begin
                        exp_start = !m_enter;
                        m_enter = 1;
                    end
                end
                m_brk = 0; m_ext = 0;
            end
        end else if (m_brk || m_ext || m_pause > 0) begin
            m_idle++;
            if (m_idle >= TO + 1) begin
                m_brk = 0; m_ext = 0; m_pause = 0;
            end
        end
        exp_event = (prev != m_keys) || exp_start;
    endtask

    function automatic logic [9:0] dut_keys();
        return {bus.fire2, bus.fire1, bus.right2, bus.down2, bus.left2, bus.up2,
                bus.right1, bus.down1, bus.left1, bus.up1};
    endfunction

    // Entered and left #1 after a rising edge
    task automatic cyc(input bit en, input logic [7:0] d, input bit clr);
        bus.ps2_data    = d;
        bus.ps2_data_en = en;
        bus.clear_keys  = clr;
        @(posedge CLOCK_50);
        #1;
        bus.ps2_data_en = 1'b0;
        bus.clear_keys  = 1'b0;
        model_step(en, d, clr);
        if (bus.start_game === 1'b1) start_seen++;
        check("keys", 32'(dut_keys()), 32'(m_keys));
        check("key_event", 32'(bus.key_event), 32'(exp_event));
        check("start_game", 32'(bus.start_game), 32'(exp_start));
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] pool [15];

    initial begin
        logic [7:0] b;
        int r;
        pool = '{8'hF0, 8'hE0, 8'hE1, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29,
                 8'h70, 8'h5A, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h00};
        rstn = 1'b0;
        bus.ps2_data = 8'h00;
        bus.ps2_data_en = 1'b0;
        bus.clear_keys = 1'b0;
        model_reset();
        #25;
        check("reset_keys", 32'(dut_keys()), 32'h0);
        check("reset_event", 32'(bus.key_event), 32'h0);
        check("reset_start", 32'(bus.start_game), 32'h0);
        @(negedge CLOCK_50);
        rstn = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // Make and break of W
        send(8'h1D);
        check("w_make_up1", 32'(bus.up1), 32'h1);
        idle(1);
        send(8'hF0); send(8'h1D);
        check("w_break_up1", 32'(bus.up1), 32'h0);

        // Extended up2 alongside up1
        send(8'hE0); send(8'h75); send(8'h1D);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_up2_off", 32'(bus.up2), 32'h0);
        check("ext_up1_kept", 32'(bus.up1), 32'h1);
        cyc(1'b0, 8'h00, 1'b1);

        // Extended codes that alias non-extended keys
        send(8'hE0); send(8'h1D); send(8'hE0); send(8'h5A); send(8'hE0); send(8'h70);

        // Enter typematic
        start_seen = 0;
        send(8'h5A); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A); send(8'h5A);
        idle(2);
        check("start_pulses", 32'(start_seen), 32'd2);

        // Abandoned E0 prefix
        cyc(1'b0, 8'h00, 1'b1);
        send(8'hE0);
        idle(TO + 10);
        send(8'h1D);
        check("timeout_up1", 32'(bus.up1), 32'h1);

        // Pause sequence swallows its tail
        send(8'hE1);
        send(8'h14); send(8'h77); send(8'h1D); send(8'hE1); send(8'hF0); send(8'h1C); send(8'h77);
        send(8'h29);
        check("pause_fire1", 32'(bus.fire1), 32'h1);

        // Clear wins over a same-cycle strobe
        cyc(1'b0, 8'h00, 1'b1);
        send(8'h1C); send(8'h29);
        cyc(1'b1, 8'h23, 1'b1);
        check("clear_right1", 32'(bus.right1), 32'h0);
        check("clear_event", 32'(bus.key_event), 32'h1);

        // Asynchronous reset mid-sequence
        send(8'h1D);
        send(8'hE0); send(8'hF0);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_keys", 32'(dut_keys()), 32'h0);
        model_reset();
        #2;
        rstn = 1'b1;
        @(posedge CLOCK_50);
        #1;
        send(8'h72);
        check("rst_72_down2", 32'(bus.down2), 32'h0);
        cyc(1'b0, 8'h00, 1'b1);
        send(8'hE0); send(8'hF0);
        #3;
        rstn = 1'b0;
        #2;
        model_reset();
        rstn = 1'b1;
        @(posedge CLOCK_50);
        #1;
        send(8'h1D);
        check("rst_then_up1", 32'(bus.up1), 32'h1);

        // Random byte streams
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) b = 8'($urandom);
            else b = pool[$urandom_range(0, 14)];
            cyc(1'b1, b, r < 3);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
